// File: rtl/dram_responder.sv
// dram_responder: single-outstanding request/response front end to an
// internal 2^AW x 32-bit word array. It supports byte, half and word
// loads and stores. Sub-word stores are done as a read-modify-write.
// Optional build macro: DRAM_RESP_MISALIGN_CHECK_EN. When it is defined,
// a misaligned half or word request is rejected with rsp_err.
module dram_responder #(
  parameter int AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t         state_q;
  logic           we_q;
  logic [2:0]     size_q;
  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic           req_ready_q;
  logic           rsp_valid_q;
  logic [31:0]    rsp_rdata_q;
  logic           rsp_err_q;

  logic [31:0]    mem [2**AW];

  logic [31:0]    cur_word;
  logic [31:0]    load_d;
  logic [31:0]    merge_d;
  logic [7:0]     lane8;
  logic [15:0]    lane16;
  logic           misalign;
  logic           reject;

  // Address bits above the array are deliberately dropped, so addresses wrap.
  logic           unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Decide at acceptance whether the request is rejected without touching the array.
  always_comb begin
`ifdef DRAM_RESP_MISALIGN_CHECK_EN
    misalign = ((req_size[1:0] == SZ_HALF) && req_addr[0]) ||
               ((req_size[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    reject = (req_size[1:0] == SZ_ILL) || misalign;
  end

  // Extract or extend the load data and build the merged word for sub-word stores.
  always_comb begin
    // NOTE: every output of this block gets a default first, so that no path leaves it unassigned and no latch is inferred.
    cur_word = mem[addr_q[AW+1:2]];
    lane8    = cur_word[{addr_q[1:0], 3'b000} +: 8];
    lane16   = cur_word[{addr_q[1], 4'b0000} +: 16];
    load_d   = cur_word;
    merge_d  = cur_word;
    case (size_q[1:0])
      SZ_BYTE: begin
        load_d = size_q[2] ? {24'h0, lane8} : {{24{lane8[7]}}, lane8};
        merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_d = size_q[2] ? {16'h0, lane16} : {{16{lane16[15]}}, lane16};
        merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        load_d  = cur_word;
        merge_d = wdata_q;
      end
    endcase
  end

  // Control FSM: accepts one request, sequences the array access and holds the response.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
    if (!rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= req_size;
            addr_q      <= req_addr[AW+1:0];
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (reject) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'h0;
              rsp_err_q   <= 1'b1;
            end else if (req_we && (req_size[1:0] == SZ_WORD)) begin
              state_q <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            wdata_q <= merge_d;
            state_q <= WRITE;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_d;
            rsp_err_q   <= 1'b0;
          end
        end
        WRITE: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= 32'h0;
          rsp_err_q   <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array write on the WRITE edge. A reset forces IDLE asynchronously, which aborts a pending write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array deliberately has no reset. Its contents survive rst, and it can map onto RAM.
    if (state_q == WRITE) begin
      mem[addr_q[AW+1:2]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Directed self-checking bench for dram_responder.
// The expected values are computed by hand from the byte-lane layout.
module tb_dram_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec = 0;
  int n_err = 0;

  dram_responder #(.AW(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, measure the latency to rsp_valid, check the response,
  // optionally hold rsp_ready low for `hold` cycles, then retire the request.
  task automatic do_req(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold);
    int lat;
    @(negedge clk);
    check({tag, ".req_ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 3'b111;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hDEAD_BEEF;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, {31'h0, rsp_valid}, 32'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, exp_rdata);
      check({tag, ".hold_ready"}, {31'h0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".done_valid"}, {31'h0, rsp_valid}, 32'd0);
    check({tag, ".done_ready"}, {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.req_ready", {31'h0, req_ready}, 32'd1);
    check("rst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'h0);
    check("rst.rsp_err",   {31'h0, rsp_err}, 32'd0);
    rst = 1'b1;

    // Word store, then word load back.
    do_req("st_w40",  1'b1, 3'b010, 32'h40, 32'h1234_5678, 2, 32'h0, 1'b0, 0);
    do_req("ld_w40",  1'b0, 3'b010, 32'h40, 32'h0, 2, 32'h1234_5678, 1'b0, 0);
    // Byte store into lane 2, then word, signed and unsigned byte loads.
    do_req("st_b42",  1'b1, 3'b000, 32'h42, 32'hFFFF_FFAB, 3, 32'h0, 1'b0, 0);
    do_req("ld_w40b", 1'b0, 3'b010, 32'h40, 32'h0, 2, 32'h12AB_5678, 1'b0, 0);
    do_req("ld_bs42", 1'b0, 3'b000, 32'h42, 32'h0, 2, 32'hFFFF_FFAB, 1'b0, 0);
    do_req("ld_bu42", 1'b0, 3'b100, 32'h42, 32'h0, 2, 32'h0000_00AB, 1'b0, 0);
    do_req("ld_bs40", 1'b0, 3'b000, 32'h40, 32'h0, 2, 32'h0000_0078, 1'b0, 0);
    do_req("ld_bu43", 1'b0, 3'b100, 32'h43, 32'h0, 2, 32'h0000_0012, 1'b0, 0);
    // Half store into the upper half of word 0x44.
    do_req("st_w44",  1'b1, 3'b010, 32'h44, 32'h1122_3344, 2, 32'h0, 1'b0, 0);
    do_req("st_h46",  1'b1, 3'b001, 32'h46, 32'h0000_8001, 3, 32'h0, 1'b0, 0);
    do_req("ld_hs46", 1'b0, 3'b001, 32'h46, 32'h0, 2, 32'hFFFF_8001, 1'b0, 0);
    do_req("ld_hu46", 1'b0, 3'b101, 32'h46, 32'h0, 2, 32'h0000_8001, 1'b0, 0);
    do_req("ld_w44",  1'b0, 3'b010, 32'h44, 32'h0, 2, 32'h8001_3344, 1'b0, 0);
    do_req("ld_hs44", 1'b0, 3'b001, 32'h44, 32'h0, 2, 32'h0000_3344, 1'b0, 0);
    // Address wrap: bit 14 lies above the 12-bit word index.
    do_req("ld_wrap", 1'b0, 3'b010, 32'h0000_4040, 32'h0, 2, 32'h12AB_5678, 1'b0, 0);
    // Backpressure: response held for five cycles.
    do_req("bp",      1'b0, 3'b010, 32'h40, 32'h0, 2, 32'h12AB_5678, 1'b0, 5);

    // Reset while the byte store to 0x40 is in its WRITE cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 3'b000;
    req_addr  = 32'h40;
    req_wdata = 32'h0000_0055;
    @(negedge clk);          // READ
    req_valid = 1'b0;
    req_we    = 1'b0;
    @(negedge clk);          // WRITE
    rst = 1'b0;
    #1;
    check("midrst.req_ready", {31'h0, req_ready}, 32'd1);
    check("midrst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_req("ld_after_rst", 1'b0, 3'b010, 32'h40, 32'h0, 2, 32'h12AB_5678, 1'b0, 0);

    // Rejections.
`ifdef DRAM_RESP_MISALIGN_CHECK_EN
    do_req("ld_w41",  1'b0, 3'b010, 32'h41, 32'h0, 1, 32'h0, 1'b1, 0);
    do_req("ld_h41",  1'b0, 3'b001, 32'h41, 32'h0, 1, 32'h0, 1'b1, 0);
    do_req("st_w42",  1'b1, 3'b010, 32'h42, 32'hAAAA_AAAA, 1, 32'h0, 1'b1, 0);
`else
    do_req("ld_w41",  1'b0, 3'b010, 32'h41, 32'h0, 2, 32'h12AB_5678, 1'b0, 0);
    do_req("ld_h41",  1'b0, 3'b001, 32'h41, 32'h0, 2, 32'h0000_5678, 1'b0, 0);
`endif
    do_req("ld_sz11", 1'b0, 3'b011, 32'h40, 32'h0, 1, 32'h0, 1'b1, 0);
    do_req("st_sz11", 1'b1, 3'b111, 32'h40, 32'h0000_0000, 1, 32'h0, 1'b1, 0);
    do_req("ld_final",1'b0, 3'b010, 32'h40, 32'h0, 2, 32'h12AB_5678, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameter AW, default 12; the word-address width, giving an internal array of 2^AW 32-bit words.
REQ-002 SHALL have port clk  input  1  clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  responder can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  3  [1:0]: 00 = byte, 01 = half, 10 = word, 11 = illegal; [2]: 1 = zero-extend load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  requester accepts the response.
REQ-012 SHALL have port rsp_rdata  output  32  load data, right-aligned and extended.
REQ-013 SHALL have port rsp_err  output  1  the request was rejected; no array access took place.

Function
REQ-014 SHALL implement a state machine with states IDLE, READ, WRITE and RESP.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-016 SHALL register we, size, addr and wdata at acceptance; request inputs are ignored outside acceptance.
REQ-017 SHALL index the array with addr[AW+1:2]; upper address bits are ignored, so addresses wrap.
REQ-018 Load transitions: IDLE -> READ -> RESP; rsp_valid rises 2 cycles after acceptance.
REQ-019 Word store transitions: IDLE -> WRITE -> RESP; the array is written at the WRITE edge; rsp_valid rises 2 cycles after acceptance.
REQ-020 Byte/half store transitions: IDLE -> READ -> WRITE -> RESP; the write is a read-modify-write.
REQ-021 Byte/half store: only the byte lane(s) selected by addr[1:0] (byte) or addr[1] (half) SHALL be replaced; all other bits keep their old value.
REQ-022 Byte/half store: rsp_valid rises 3 cycles after acceptance.
REQ-023 Byte load SHALL return the lane selected by addr[1:0]; half load SHALL return the lane selected by addr[1].
REQ-024 Byte/half load SHALL sign-extend when size[2]=0 and zero-extend when size[2]=1; word load SHALL return the full word.
REQ-025 Rejected requests (size 11, or misaligned per REQ-036) SHALL go IDLE -> RESP with rsp_err=1 and rsp_rdata=0; rsp_valid rises 1 cycle after acceptance; the array is not accessed.
REQ-026 A store response SHALL carry rsp_rdata=0.
REQ-027 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1.
REQ-028 On a RESP edge with rsp_ready=1, the FSM SHALL return to IDLE; there is no back-to-back acceptance in that same cycle.
REQ-029 rsp_valid=0 outside RESP; rsp_ready is ignored outside RESP.
REQ-030 Since at most one request is outstanding, no access overlaps a store; a load following a store to the same word SHALL see the stored data.

Reset
REQ-031 When rst=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and all request registers are cleared.
REQ-032 Reset asserted during READ or WRITE SHALL abort the request; no array write takes place on or after assertion.
REQ-033 Array contents SHALL NOT be cleared by reset.
REQ-034 After rst deasserts, the first acceptance is possible on the first clock edge.

Configuration
REQ-035 SHALL compile the misalignment check in or out with macro DRAM_RESP_MISALIGN_CHECK_EN.
REQ-036 Macro defined: half with addr[0]=1, or word with addr[1:0]!=00, SHALL be rejected per REQ-025.
REQ-037 Macro undefined: misalignment is never detected; half uses addr[1], word ignores addr[1:0]; rsp_err=1 only for size 11.

Verification
REQ-038 SHALL cover word store then load: store 0x12345678 to 0x40, then load word from 0x40 -> rsp_rdata=0x12345678, rsp_err=0, load latency 2 cycles.
REQ-039 SHALL cover byte store and loads: after REQ-038, store byte 0xAB to 0x42 -> load word from 0x40 = 0x12AB5678; signed byte load from 0x42 = 0xFFFFFFAB; unsigned byte load from 0x42 = 0x000000AB; byte-store latency 3 cycles.
REQ-040 SHALL cover half store and loads: store half 0x8001 to 0x46, then signed half load from 0x46 = 0xFFFF8001 and unsigned half load = 0x00008001; the word at 0x44 keeps bits [15:0] unchanged.
REQ-041 SHALL cover backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata are stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-042 SHALL cover reset mid-op: assert rst during the WRITE of a byte store to 0x40 -> a later load from 0x40 returns the pre-store value.
REQ-043 SHALL cover rejection: word load from 0x41 -> with the macro, rsp_err=1 and rsp_rdata=0 after 1 cycle; without it, data of word 0x40 with rsp_err=0; size 11 -> rsp_err=1 in both builds.
